// File: rtl/aes_enc_pkg.sv
// Shared AES encipher types, round counts and byte/word helpers.
// Used by aes_encipher_lanes and aes_enc_round_dp.
package aes_enc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SBOX,
    ST_MAIN,
    ST_FINAL
  } aes_state_e;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_256 = 2'b01;
  localparam logic [1:0] KEYLEN_192 = 2'b10;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  function automatic logic [7:0] gm2(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(
    input logic [7:0] b
  );
    return gm2(b) ^ b;
  endfunction

  function automatic logic [31:0] mixw(
    input logic [31:0] w
  );
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] m0, m1, m2, m3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    m0 = gm2(b0) ^ gm3(b1) ^ b2 ^ b3;
    m1 = b0 ^ gm2(b1) ^ gm3(b2) ^ b3;
    m2 = b0 ^ b1 ^ gm2(b2) ^ gm3(b3);
    m3 = gm3(b0) ^ b1 ^ b2 ^ gm2(b3);
    return {m0, m1, m2, m3};
  endfunction

  function automatic logic [127:0] mixcolumns(
    input logic [127:0] s
  );
    return {mixw(s[127:96]), mixw(s[95:64]),
            mixw(s[63:32]), mixw(s[31:0])};
  endfunction

  // Row r of output column c comes from
  // input column (c + r) mod 4.
  function automatic logic [127:0] shiftrows(
    input logic [127:0] s
  );
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] o0, o1, o2, o3;
    w0 = s[127:96];
    w1 = s[95:64];
    w2 = s[63:32];
    w3 = s[31:0];
    o0 = {w0[31:24], w1[23:16], w2[15:8], w3[7:0]};
    o1 = {w1[31:24], w2[23:16], w3[15:8], w0[7:0]};
    o2 = {w2[31:24], w3[23:16], w0[15:8], w1[7:0]};
    o3 = {w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    return {o0, o1, o2, o3};
  endfunction

endpackage

// File: rtl/aes_enc_round_dp.sv
// Combinational round datapath: ShiftRows, optional
// MixColumns, AddRoundKey. final_i=1 skips MixColumns.
module aes_enc_round_dp
  import aes_enc_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         final_i,
  output logic [127:0] next_o
);

  logic [127:0] sr;
  logic [127:0] mc;

  always_comb begin
    sr     = shiftrows(state_i);
    mc     = mixcolumns(sr);
    next_o = (final_i ? sr : mc) ^ round_key_i;
  end

endmodule

// File: rtl/aes_encipher_lanes.sv
// AES encipher round engine with SBOX_LANES S-box words per cycle.
// Ports: clk, reset_n, next/keylen start, round/round_key key
// fetch, sboxw/new_sboxw S-box bank, block in, new_block,
// ready, valid. Define AES_ENC_KEY192_EN to enable AES-192.
module aes_encipher_lanes
  import aes_enc_pkg::*;
#(
  parameter int SBOX_LANES = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    next,
  input  logic [1:0]              keylen,
  output logic [3:0]              round,
  input  logic [127:0]            round_key,
  output logic [32*SBOX_LANES-1:0] sboxw,
  input  logic [32*SBOX_LANES-1:0] new_sboxw,
  input  logic [127:0]            block,
  output logic [127:0]            new_block,
  output logic                    ready,
  output logic                    valid
);

  localparam int W = 4 / SBOX_LANES;
  localparam int SW_BITS = (W > 1) ? $clog2(W) : 1;

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 ||
        SBOX_LANES == 4)) begin : g_bad_lanes
    $error("SBOX_LANES must be 1, 2 or 4");
  end

  aes_state_e         state_q, state_d;
  logic [3:0]         round_ctr_q, round_ctr_d;
  logic [SW_BITS-1:0] sword_ctr_q, sword_ctr_d;
  logic [127:0]       block_q, block_d;
  logic [1:0]         keylen_q, keylen_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;

  logic [3:0]         nr;
  logic               last_step;
  logic [127:0]       dp_next;

  aes_enc_round_dp u_dp (
    .state_i     (block_q),
    .round_key_i (round_key),
    .final_i     (state_q == ST_FINAL),
    .next_o      (dp_next)
  );

  always_comb begin
    nr = NR_128;
    unique case (1'b1)
      (keylen_q == KEYLEN_256): nr = NR_256;
`ifdef AES_ENC_KEY192_EN
      (keylen_q == KEYLEN_192): nr = NR_192;
`endif
      default: nr = NR_128;
    endcase
  end

  // For W=1 the counter is pinned at 0, so every step is last.
  assign last_step = (sword_ctr_q == SW_BITS'(W - 1));

  // Lane l of step s reads word s*SBOX_LANES+l.
  always_comb begin
    sboxw = '0;
    if (state_q == ST_SBOX) begin
      for (int l = 0; l < SBOX_LANES; l++) begin
        sboxw[32*l +: 32] = block_q[
          (3 - (int'(sword_ctr_q) * SBOX_LANES + l)) * 32 +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    round_ctr_d = round_ctr_q;
    sword_ctr_d = sword_ctr_q;
    block_d     = block_q;
    keylen_d    = keylen_q;
    ready_d     = ready_q;
    valid_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (next) begin
          state_d     = ST_INIT;
          ready_d     = 1'b0;
          round_ctr_d = 4'd0;
          keylen_d    = keylen;
        end
      end
      ST_INIT: begin
        block_d     = block ^ round_key;
        round_ctr_d = 4'd1;
        sword_ctr_d = '0;
        state_d     = ST_SBOX;
      end
      ST_SBOX: begin
        for (int l = 0; l < SBOX_LANES; l++) begin
          block_d[
            (3 - (int'(sword_ctr_q) * SBOX_LANES + l)) * 32 +: 32]
            = new_sboxw[32*l +: 32];
        end
        if (last_step) begin
          sword_ctr_d = '0;
          state_d = (round_ctr_q == nr) ? ST_FINAL : ST_MAIN;
        end else begin
          sword_ctr_d = sword_ctr_q + SW_BITS'(1);
        end
      end
      ST_MAIN: begin
        block_d     = dp_next;
        round_ctr_d = round_ctr_q + 4'd1;
        sword_ctr_d = '0;
        state_d     = ST_SBOX;
      end
      ST_FINAL: begin
        block_d = dp_next;
        ready_d = 1'b1;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      round_ctr_q <= 4'd0;
      sword_ctr_q <= '0;
      block_q     <= '0;
      keylen_q    <= KEYLEN_128;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_ctr_q <= round_ctr_d;
      sword_ctr_q <= sword_ctr_d;
      block_q     <= block_d;
      keylen_q    <= keylen_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
    end
  end

  assign round     = round_ctr_q;
  assign new_block = block_q;
  assign ready     = ready_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_aes_encipher_lanes.sv
// Bench for aes_encipher_lanes at SBOX_LANES = 1, 2, 4.
// Supplies S-box and FIPS-197 round keys from local models.
module tb_aes_encipher_lanes;

  localparam logic [127:0] PT =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 =
    128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 =
    128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         reset_n;
  logic [2:0]   nxt;
  logic [1:0]   keylen;
  logic [127:0] blk;

  logic         rdy_a  [3];
  logic         vld_a  [3];
  logic         sbnz_a [3];
  logic [3:0]   rnd_a  [3];
  logic [127:0] nb_a   [3];

  logic [127:0] rk [15];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as b^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] r;
    x = gmul(b, b);
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      r = gmul(r, x);
      x = gmul(x, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^
           {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic build_keys(input int nk);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [255:0] key;
    int nr;
    if (nk == 4)
      key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    else if (nk == 6)
      key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
             64'h0};
    else
      key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = 1 << g;
    logic [32*L-1:0] sw;
    logic [32*L-1:0] nsw;
    logic [127:0]    rkey;
    assign rkey = rk[rnd_a[g]];
    assign sbnz_a[g] = |sw;
    for (genvar l = 0; l < L; l++) begin : g_lane
      assign nsw[32*l +: 32] = subw(sw[32*l +: 32]);
    end
    aes_encipher_lanes #(.SBOX_LANES(L)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .next      (nxt[g]),
      .keylen    (keylen),
      .round     (rnd_a[g]),
      .round_key (rkey),
      .sboxw     (sw),
      .new_sboxw (nsw),
      .block     (blk),
      .new_block (nb_a[g]),
      .ready     (rdy_a[g]),
      .valid     (vld_a[g])
    );
  end

  task automatic chk(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic start_op(input int d, input logic [1:0] kl);
    @(negedge clk);
    keylen = kl;
    nxt[d] = 1'b1;
    @(posedge clk);
    #1;
    nxt[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!vld_a[d] && lat < 200);
  endtask

  typedef struct {
    int           d;
    logic [1:0]   kl;
    int           nk;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  vec_t vt[$];

  initial begin
    int lat, e, pulses, first, p1, p2, rhigh;
    logic [127:0] ct;

    reset_n = 1'b0;
    nxt     = '0;
    keylen  = 2'b00;
    blk     = PT;
    build_keys(4);

    vt.push_back('{0, 2'b00, 4, CT128, 51});
    vt.push_back('{1, 2'b00, 4, CT128, 31});
    vt.push_back('{2, 2'b00, 4, CT128, 21});
    vt.push_back('{0, 2'b01, 8, CT256, 71});
    vt.push_back('{2, 2'b01, 8, CT256, 29});
    vt.push_back('{1, 2'b11, 4, CT128, 31});
`ifdef AES_ENC_KEY192_EN
    vt.push_back('{0, 2'b10, 6, CT192, 61});
    vt.push_back('{1, 2'b10, 6, CT192, 37});
`else
    vt.push_back('{0, 2'b10, 4, CT128, 51});
`endif

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d_ready", d), 128'(rdy_a[d]), 128'd1);
      chk($sformatf("rst%0d_valid", d), 128'(vld_a[d]), 128'd0);
      chk($sformatf("rst%0d_block", d), nb_a[d], 128'd0);
      chk($sformatf("rst%0d_round", d), 128'(rnd_a[d]), 128'd0);
      chk($sformatf("rst%0d_sboxw", d), 128'(sbnz_a[d]), 128'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      build_keys(vt[i].nk);
      start_op(vt[i].d, vt[i].kl);
      chk($sformatf("v%0d_init_ready", i),
          128'(rdy_a[vt[i].d]), 128'd0);
      chk($sformatf("v%0d_init_round", i),
          128'(rnd_a[vt[i].d]), 128'd0);
      wait_valid(vt[i].d, lat);
      chk($sformatf("v%0d_latency", i), 128'(lat), 128'(vt[i].lat));
      chk($sformatf("v%0d_ct", i), nb_a[vt[i].d], vt[i].ct);
      chk($sformatf("v%0d_ready", i), 128'(rdy_a[vt[i].d]), 128'd1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid_clr", i),
          128'(vld_a[vt[i].d]), 128'd0);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d_hold", i), nb_a[vt[i].d], vt[i].ct);
    end

    // next pulsed mid-operation is ignored
    build_keys(4);
    start_op(0, 2'b00);
    pulses = 0;
    first  = 0;
    ct     = '0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) nxt[0] = 1'b1;
      if (k == 11) nxt[0] = 1'b0;
      if (vld_a[0]) begin
        pulses++;
        if (first == 0) begin
          first = k;
          ct = nb_a[0];
        end
      end
    end
    chk("midnext_pulses", 128'(pulses), 128'd1);
    chk("midnext_latency", 128'(first), 128'd51);
    chk("midnext_ct", ct, CT128);

    // next held high: back-to-back ops
    @(negedge clk);
    keylen = 2'b00;
    nxt[2] = 1'b1;
    @(posedge clk);
    pulses = 0;
    p1 = 0;
    p2 = 0;
    rhigh = 0;
    ct = '0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (k == 40) nxt[2] = 1'b0;
      if (vld_a[2]) begin
        pulses++;
        if (p1 == 0) p1 = k;
        else if (p2 == 0) begin
          p2 = k;
          ct = nb_a[2];
        end
      end
      if (rdy_a[2] && p1 != 0 && p2 == 0) rhigh++;
    end
    chk("held_pulses", 128'(pulses), 128'd2);
    chk("held_first", 128'(p1), 128'd21);
    chk("held_second", 128'(p2), 128'd43);
    chk("held_ready_cycles", 128'(rhigh), 128'd1);
    chk("held_ct", ct, CT128);

    // reset during round 5
    start_op(0, 2'b00);
    e = 0;
    while (rnd_a[0] != 4'd5 && e < 100) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk("rstmid_reach_r5", 128'(rnd_a[0]), 128'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_ready", 128'(rdy_a[0]), 128'd1);
    chk("rstmid_valid", 128'(vld_a[0]), 128'd0);
    chk("rstmid_block", nb_a[0], 128'd0);
    chk("rstmid_round", 128'(rnd_a[0]), 128'd0);
    chk("rstmid_sboxw", 128'(sbnz_a[0]), 128'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (vld_a[0]) pulses++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (vld_a[0]) pulses++;
    end
    chk("rstmid_no_valid", 128'(pulses), 128'd0);
    chk("rstmid_idle_ready", 128'(rdy_a[0]), 128'd1);
    start_op(0, 2'b00);
    wait_valid(0, lat);
    chk("rstmid_again_latency", 128'(lat), 128'd51);
    chk("rstmid_again_ct", nb_a[0], CT128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
